// File: rtl/systolic_array_os_ctrl.sv
// Output-stationary systolic array with built-in input skew, valid/first tagged beats and a
// stream/flush/drain controller. Define SYSTOLIC_ARRAY_SAT_EN for saturating accumulators and out_sat.
module systolic_array_os_ctrl #(
    parameter int ARRAY_N      = 8,
    parameter int ARRAY_M      = 8,
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter int SIGNED       = 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic                                             in_last,
    input  logic [ARRAY_N*ACT_WIDTH-1:0]                     act_data_set_in,
    input  logic [ARRAY_M*WGT_WIDTH-1:0]                     wgt_data_set_in,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic                                             out_last,
    output logic [((ARRAY_N > 1) ? $clog2(ARRAY_N) : 1)-1:0] out_row_idx,
    output logic [ARRAY_M*PE_OUT_WIDTH-1:0]                  result_data_set_out,
    output logic                                             busy
`ifdef SYSTOLIC_ARRAY_SAT_EN
    ,
    output logic                                             out_sat
`endif
);

    localparam int RW       = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam int W        = PE_OUT_WIDTH;
    localparam int AT       = ACT_WIDTH + 2;
    localparam int WT       = WGT_WIDTH + 2;
    localparam int SKEW_LEN = ARRAY_N + ARRAY_M - 1;
    localparam int CW       = $clog2(ARRAY_N + ARRAY_M);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(ARRAY_N + ARRAY_M - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t        state, next_state;
    logic [CW-1:0] flush_cnt;
    logic [RW-1:0] row;
    logic          accept;
    logic          first_beat;

    assign accept     = in_valid & in_ready;
    assign first_beat = accept & (state == IDLE);

    // Lane shift registers: {valid, first, data}. Element j is loaded j edges after the accept,
    // so PE(n,m) reads act lane n and wgt lane m at index n+m.
    logic [AT-1:0] act_sh [ARRAY_N][SKEW_LEN];
    logic [WT-1:0] wgt_sh [ARRAY_M][SKEW_LEN];

    // NOTE: skew lanes and accumulators are reset too; a stale valid tag would corrupt the next tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < ARRAY_N; n++)
                for (int j = 0; j < SKEW_LEN; j++)
                    act_sh[n][j] <= '0;
            for (int m = 0; m < ARRAY_M; m++)
                for (int j = 0; j < SKEW_LEN; j++)
                    wgt_sh[m][j] <= '0;
        end else begin
            for (int n = 0; n < ARRAY_N; n++) begin
                act_sh[n][0] <= {accept, first_beat, act_data_set_in[n*ACT_WIDTH +: ACT_WIDTH]};
                for (int j = 1; j < SKEW_LEN; j++)
                    act_sh[n][j] <= act_sh[n][j-1];
            end
            for (int m = 0; m < ARRAY_M; m++) begin
                wgt_sh[m][0] <= {accept, first_beat, wgt_data_set_in[m*WGT_WIDTH +: WGT_WIDTH]};
                for (int j = 1; j < SKEW_LEN; j++)
                    wgt_sh[m][j] <= wgt_sh[m][j-1];
            end
        end
    end

    logic [W-1:0] acc_q [ARRAY_N][ARRAY_M];
`ifdef SYSTOLIC_ARRAY_SAT_EN
    logic         sat_q [ARRAY_N][ARRAY_M];
`endif

    for (genvar n = 0; n < ARRAY_N; n++) begin : g_row
        for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
            logic [AT-1:0] a_tag;
            logic [WT-1:0] w_tag;
            logic [W-1:0]  a_x, w_x, prod, acc;
            logic          upd, first;

            assign a_tag = act_sh[n][n+m];
            assign w_tag = wgt_sh[m][n+m];
            assign upd   = a_tag[AT-1] & w_tag[WT-1];
            assign first = a_tag[AT-2] & w_tag[WT-2];

            // Operands widened to the accumulator width; the product always fits, so a
            // W-bit multiply gives the exact extended product.
            if (SIGNED != 0) begin : g_sx
                assign a_x = W'($signed(a_tag[ACT_WIDTH-1:0]));
                assign w_x = W'($signed(w_tag[WGT_WIDTH-1:0]));
            end else begin : g_zx
                assign a_x = W'(a_tag[ACT_WIDTH-1:0]);
                assign w_x = W'(w_tag[WGT_WIDTH-1:0]);
            end
            assign prod = a_x * w_x;

`ifdef SYSTOLIC_ARRAY_SAT_EN
            logic [W:0]   sum;
            logic         ovf;
            logic [W-1:0] sat_val;
            logic         sat_r;

            if (SIGNED != 0) begin : g_ssat
                assign sum     = {acc[W-1], acc} + {prod[W-1], prod};
                assign ovf     = sum[W] ^ sum[W-1];
                assign sat_val = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin : g_usat
                assign sum     = {1'b0, acc} + {1'b0, prod};
                assign ovf     = sum[W];
                assign sat_val = '1;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc   <= '0;
                    sat_r <= 1'b0;
                end else if (upd) begin
                    if (first) begin
                        acc   <= prod;
                        sat_r <= 1'b0;
                    end else if (ovf) begin
                        acc   <= sat_val;
                        sat_r <= 1'b1;
                    end else begin
                        acc   <= sum[W-1:0];
                    end
                end
            end
            assign sat_q[n][m] = sat_r;
`else
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    acc <= '0;
                else if (upd)
                    acc <= first ? prod : acc + prod;
            end
`endif
            assign acc_q[n][m] = acc;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = in_last ? FLUSH : STREAM;
            STREAM:  if (accept && in_last) next_state = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) next_state = DRAIN;
            DRAIN:   if (out_ready && row == ROW_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            STREAM:  in_ready  = 1'b1;
            DRAIN:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // The last PE updates N+M-1 edges after the in_last accept; the extra count makes the
    // first result row appear N+M cycles after that accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flush_cnt <= '0;
        else if (state == FLUSH)
            flush_cnt <= flush_cnt + CW'(1);
        else
            flush_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            row <= '0;
        else if (out_valid && out_ready)
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
    end

    assign out_last    = out_valid && (row == ROW_LAST);
    assign out_row_idx = row;

    always_comb begin
        result_data_set_out = '0;
        if (out_valid)
            for (int m = 0; m < ARRAY_M; m++)
                result_data_set_out[m*W +: W] = acc_q[row][m];
    end

`ifdef SYSTOLIC_ARRAY_SAT_EN
    always_comb begin
        out_sat = 1'b0;
        if (out_valid)
            for (int m = 0; m < ARRAY_M; m++)
                out_sat = out_sat | sat_q[row][m];
    end
`endif

endmodule

// File: tb/tb_systolic_array_os_ctrl.sv
// Randomised scoreboard bench for systolic_array_os_ctrl (4x4, 16-bit signed accumulators);
// expected rows come from a plain matrix-product model of each tile.
module tb_systolic_array_os_ctrl;

    localparam int N   = 4;
    localparam int M   = 4;
    localparam int AW  = 8;
    localparam int WW  = 8;
    localparam int W   = 16;
    localparam int SG  = 1;
    localparam int RW  = 2;
    localparam int AVW = N * AW;
    localparam int WVW = M * WW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic [AVW-1:0] act = '0;
    logic [WVW-1:0] wgt = '0;
    logic           in_ready, out_valid, out_last, busy;
    logic [RW-1:0]  out_row_idx;
    logic [M*W-1:0] result;
`ifdef SYSTOLIC_ARRAY_SAT_EN
    logic           out_sat;
`endif

    systolic_array_os_ctrl #(
        .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(AW), .WGT_WIDTH(WW),
        .PE_OUT_WIDTH(W), .SIGNED(SG)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .act_data_set_in(act), .wgt_data_set_in(wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_row_idx(out_row_idx), .result_data_set_out(result),
        .busy(busy)
`ifdef SYSTOLIC_ARRAY_SAT_EN
        , .out_sat(out_sat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M*W-1:0] data;
        int             idx;
        bit             last;
        bit             sat;
    } row_t;

    row_t           sb_q[$];
    int             rise_q[$];
    logic [AVW-1:0] tile_a[$];
    logic [WVW-1:0] tile_w[$];
    int             n_vec = 0;
    int             n_err = 0;
    bit             hold_mode = 1'b0;
    int             hold_cnt = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    function automatic longint lane_val(input logic [31:0] raw, input int width);
        longint x = longint'(raw);
        if (SG != 0 && raw[width-1])
            x = x - (longint'(1) << width);
        return x;
    endfunction

    // Reference: C[n][m] = sum_k A[k][n] * W[k][m], reduced to the accumulator range.
    task automatic push_expected(input int acc_cyc);
        longint acc [N][M];
        bit     st  [N][M];
        longint p, s, t;
        row_t   r;
`ifdef SYSTOLIC_ARRAY_SAT_EN
        longint hi = (SG != 0) ? (longint'(1) << (W-1)) - 1 : (longint'(1) << W) - 1;
        longint lo = (SG != 0) ? -(longint'(1) << (W-1)) : 0;
`endif
        for (int k = 0; k < tile_a.size(); k++)
            for (int n = 0; n < N; n++)
                for (int m = 0; m < M; m++) begin
                    p = lane_val(32'(tile_a[k][n*AW +: AW]), AW) *
                        lane_val(32'(tile_w[k][m*WW +: WW]), WW);
                    if (k == 0) begin
                        acc[n][m] = p;
                        st[n][m]  = 1'b0;
                    end else begin
                        s = acc[n][m] + p;
`ifdef SYSTOLIC_ARRAY_SAT_EN
                        if (s > hi) begin s = hi; st[n][m] = 1'b1; end
                        else if (s < lo) begin s = lo; st[n][m] = 1'b1; end
`endif
                        acc[n][m] = s;
                    end
                end
        for (int n = 0; n < N; n++) begin
            r.data = '0;
            r.sat  = 1'b0;
            for (int m = 0; m < M; m++) begin
                t = acc[n][m];
                r.data[m*W +: W] = t[W-1:0];
                r.sat = r.sat | st[n][m];
            end
            r.idx  = n;
            r.last = (n == N-1);
            sb_q.push_back(r);
        end
        rise_q.push_back(acc_cyc + N + M);
        tile_a.delete();
        tile_w.delete();
    endtask

    task automatic drive_beat(input logic [AVW-1:0] a, input logic [WVW-1:0] w,
                              input bit last, output int acc_cyc);
        int guard = 0;
        while (!in_ready) begin
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            act      = AVW'($urandom);
            wgt      = WVW'($urandom);
            @(posedge clk); #1;
            guard++;
            if (guard > 300) begin
                n_err++;
                $display("FAIL in_ready_wait: got in_ready=0 for %0d cycles expected 1", guard);
                summary();
                $fatal(1);
            end
        end
        in_valid = 1'b1;
        in_last  = last;
        act      = a;
        wgt      = w;
        @(posedge clk); #1;
        acc_cyc = cyc;
        tile_a.push_back(a);
        tile_w.push_back(w);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        act      = AVW'($urandom);
        wgt      = WVW'($urandom);
    endtask

    task automatic bubbles(input int nb);
        repeat (nb) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            act      = AVW'($urandom);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [7:0] pick(input int mode, input int lane, input bit is_wgt);
        logic [7:0] corner [5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
        case (mode)
            1:       return is_wgt ? 8'd1 : 8'(lane + 1);
            2:       return is_wgt ? 8'd3 : 8'd2;
            3:       return 8'h80;
            4:       return 8'h7F;
            5:       return corner[$urandom_range(0, 4)];
            default: return 8'($urandom);
        endcase
    endfunction

    // gap < 0: random 0..2 bubbles between beats; otherwise 'gap' bubbles after the first beat only.
    task automatic run_tile(input int k, input int mode, input int gap);
        logic [AVW-1:0] a;
        logic [WVW-1:0] w;
        int             c = 0;
        for (int i = 0; i < k; i++) begin
            for (int n = 0; n < N; n++) a[n*AW +: AW] = pick(mode, n, 1'b0);
            for (int m = 0; m < M; m++) w[m*WW +: WW] = pick(mode, m, 1'b1);
            drive_beat(a, w, (i == k-1), c);
            if (i < k-1) begin
                if (gap < 0) bubbles($urandom_range(0, 2));
                else if (i == 0) bubbles(gap);
            end
        end
        push_expected(c);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb_q.size() != 0 || rise_q.size() != 0) && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_rows_left", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (hold_mode && out_valid && out_row_idx == 2'd1 && hold_cnt < 5) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    bit   prev_v = 1'b0;
    bit   chk_idle = 1'b0;
    row_t mon_exp;

    always @(negedge clk) begin
        if (!reset) begin
            prev_v   = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_drain", 128'({out_valid, busy}), 128'(0));
                chk_idle = 1'b0;
            end
            if (out_valid) begin
                if (!prev_v) begin
                    if (rise_q.size() == 0) check("unexpected_rise", 128'(out_valid), 128'(0));
                    else check("first_valid_cycle", 128'(cyc), 128'(rise_q.pop_front()));
                end
                if (sb_q.size() == 0) begin
                    check("unexpected_row", 128'(out_valid), 128'(0));
                end else begin
                    mon_exp = sb_q[0];
                    check("row_data", 128'(result), 128'(mon_exp.data));
                    check("row_idx", 128'(out_row_idx), 128'(mon_exp.idx));
                    check("row_last", 128'(out_last), 128'(mon_exp.last));
                    check("in_ready_drain", 128'(in_ready), 128'(0));
`ifdef SYSTOLIC_ARRAY_SAT_EN
                    check("row_sat", 128'(out_sat), 128'(mon_exp.sat));
`endif
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        if (mon_exp.last) chk_idle = 1'b1;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: got no finish by %0t expected completion", $time);
        summary();
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_row_idx", 128'(out_row_idx), 128'(0));
        check("rst_result", 128'(result), 128'(0));
        @(posedge clk); #1;

        run_tile(1, 1, 0);
        run_tile(3, 2, 2);
        run_tile(4, 3, 0);
        run_tile(1, 3, 0);
        run_tile(3, 4, 0);
        wait_drain();

        hold_cnt  = 0;
        hold_mode = 1'b1;
        run_tile(2, 0, 1);
        wait_drain();
        hold_mode = 1'b0;
        check("hold_cycles", 128'(hold_cnt), 128'(5));

        drive_beat(AVW'($urandom), WVW'($urandom), 1'b0, c);
        drive_beat(AVW'($urandom), WVW'($urandom), 1'b0, c);
        #2 reset = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_result", 128'(result), 128'(0));
        tile_a.delete();
        tile_w.delete();
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        bubbles(N + M + 4);

        repeat (30) begin
            run_tile($urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? 5 : 0, -1);
        end
        wait_drain();
        repeat (3) @(posedge clk);
        summary();
        $finish;
    end

endmodule

// File: doc/systolic_array_os_ctrl.md
Name: systolic_array_os_ctrl

Overview:
Parametrised output-stationary systolic array for signed or unsigned int matrix multiply. Integrated input skew, valid-tagged bubble handling, and a stream/flush/drain controller with ready/valid handshakes on both sides. It sits between the ibuf/wbuf readers and the output buffer writer, replacing the fixed-timing array plus external skew logic. Accumulators are local to each PE; results drain one row per handshake.

Parameters:
ARRAY_N, 8, rows (activation lanes)
ARRAY_M, 8, columns (weight lanes)
ACT_WIDTH, 8, activation width
WGT_WIDTH, 8, weight width
PE_OUT_WIDTH, 32, accumulator/result width (must be >= ACT_WIDTH+WGT_WIDTH)
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
in_valid  in  1  input beat valid
in_ready  out  1  array accepts a beat
in_last  in  1  final K-beat of the current tile, qualified by in_valid
act_data_set_in  in  ARRAY_N*ACT_WIDTH  activation column, lane n at [n*ACT_WIDTH+:ACT_WIDTH]
wgt_data_set_in  in  ARRAY_M*WGT_WIDTH  weight row, lane m at [m*WGT_WIDTH+:WGT_WIDTH]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_last  out  1  row ARRAY_N-1 of the tile
out_row_idx  out  max(1,$clog2(ARRAY_N))  row index being presented
result_data_set_out  out  ARRAY_M*PE_OUT_WIDTH  accumulators of row out_row_idx, column m at [m*PE_OUT_WIDTH+:PE_OUT_WIDTH]
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, all accumulators, skew regs and valid tags 0. in_ready=1 after release; out_valid, out_last, out_row_idx, busy and result_data_set_out are 0. Reset mid-tile discards all in-flight data.
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
- IDLE: in_ready=1. Accepted beat -> STREAM; that beat's tag is marked "first", so each PE overwrites rather than adds. If in_last is also set, go directly to FLUSH (K=1).
- STREAM: in_ready=1. in_valid=0 inserts a bubble; its tag is invalid and no PE accumulates. Accepted beat with in_last -> FLUSH.
- Skew: act lane n delayed n cycles, then moves right one PE per cycle. Wgt lane m delayed m cycles, then moves down one PE per cycle. Each carries a valid/first tag. PE(n,m) sees beat k at accept edge + n + m and updates its accumulator on the following edge.
- MAC: product is sign- or zero-extended per SIGNED to PE_OUT_WIDTH. acc = first ? prod : acc + prod. Overflow wraps modulo 2^PE_OUT_WIDTH.
- FLUSH: in_ready=0. Counter runs exactly ARRAY_N+ARRAY_M-1 cycles, then DRAIN. The first out_valid rises ARRAY_N+ARRAY_M cycles after the edge that accepted the in_last beat.
- DRAIN: in_ready=0, out_valid=1. Row r starts at 0 and advances on out_valid&out_ready. While out_ready=0, result_data_set_out and out_row_idx are held stable. out_last=1 when r=ARRAY_N-1. The handshake on the last row -> IDLE, out_valid=0 the next cycle.
- in_valid while in_ready=0 is ignored. in_last outside an accepted beat is ignored.

Optional Feature:
Macro SYSTOLIC_ARRAY_SAT_EN.
- Defined: accumulate saturates to the signed range [-2^(PE_OUT_WIDTH-1), 2^(PE_OUT_WIDTH-1)-1] (SIGNED=1) or to [0, 2^PE_OUT_WIDTH-1] (SIGNED=0). A per-row sticky flag is ORed into a 1-bit port out_sat, which is valid with out_valid.
- Undefined: modulo wrap, and the out_sat port is absent.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release -> in_ready=1, busy=0, out_valid=0, result_data_set_out=0. Assert reset=0 mid-STREAM -> same values immediately, no later out_valid.
- K=1, N=M=4: act={1,2,3,4}, wgt={1,1,1,1}, in_last=1 -> out_valid exactly 8 cycles later. Rows 0..3 read all-1,2,3,4 across columns, out_last on row 3, then busy=0.
- K=3 with bubbles, N=M=4: beats act=all 2, wgt=all 3, with in_valid=0 for 2 cycles between beats 1 and 2 -> every result = 18.
- Signed: SIGNED=1, act=-128, wgt=-128, K=4 -> all results 65536. SIGNED=0, act=255, wgt=255, K=1 -> all results 65025.
- Backpressure: out_ready=0 for 5 cycles while presenting row 1 -> out_row_idx=1 and data held constant. New input is refused (in_ready=0) until the last row handshake.
- Overflow, PE_OUT_WIDTH=16: act=127, wgt=127, K=3 -> without macro each result = -17149; with SYSTOLIC_ARRAY_SAT_EN = 32767 and out_sat=1.
